// File: rtl/iob_im_frame_ctrl_pkg.sv
// Shared constants for the IM frame-synchronous position controller:
// write-select encodings, reset locations, FSM state encoding and the
// default visible-area geometry.
package im_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int COORD_W_DEF  = 10;

  localparam logic [1:0] SEL_BALL   = 2'd0;
  localparam logic [1:0] SEL_BARL   = 2'd1;
  localparam logic [1:0] SEL_BARR   = 2'd2;
  localparam logic [1:0] SEL_COMMIT = 2'd3;

  // Reset locations as {y, x} coordinates.
  localparam int BALL_RST_Y = 240;
  localparam int BALL_RST_X = 320;
  localparam int BARL_RST_Y = 240;
  localparam int BARL_RST_X = 16;
  localparam int BARR_RST_Y = 240;
  localparam int BARR_RST_X = 623;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/iob_im_frame_ctrl_vblank_det.sv
// Vertical-blank rising-edge detector. vb_q resets high so that a reset
// released in the middle of vblank does not produce a spurious rise.
module im_vblank_det #(
  parameter int COORD_W  = 10,
  parameter int V_ACTIVE = 480
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] pixel_y,
  output logic               rise
);

  localparam logic [COORD_W-1:0] V_LIM = COORD_W'(V_ACTIVE);

  logic vblank;
  logic vb_q;

  assign vblank = (pixel_y >= V_LIM);
  assign rise   = vblank && !vb_q;

  // Remember last cycle's vblank level for edge detection.
  always_ff @(posedge clk) begin
    if (!rst) vb_q <= 1'b1;
    else      vb_q <= vblank;
  end

endmodule

// File: rtl/iob_reg.sv
// Generic enabled register with synchronous active-low reset to RST_VAL.
module iob_reg #(
  parameter int                 DATA_W  = 1,
  parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  // Load data_in when enabled; return to RST_VAL on reset.
  always_ff @(posedge clk) begin
    if (!rst) data_out <= RST_VAL;
    else if (en) data_out <= data_in;
  end

endmodule

// File: rtl/iob_im_frame_ctrl.sv
// Frame-synchronous position controller. The CPU writes ball/bar positions
// into staging registers; a commit request copies all three into the active
// registers atomically at the next vblank rise so the renderer never sees a
// torn frame. Also provides a per-frame tick and a 16-bit frame counter.
//
// Handshake: a write (staging or commit request) is accepted in any cycle
// where wr_valid && wr_ready. wr_ready drops only during the single COMMIT
// cycle, so staging cannot change while it is being copied.
module iob_im_frame_ctrl
  import im_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int COORD_W  = COORD_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [COORD_W-1:0]   pixel_x,
  input  logic [COORD_W-1:0]   pixel_y,
  input  logic                 wr_valid,
  input  logic [1:0]           wr_sel,
  input  logic [2*COORD_W-1:0] wr_data,
  output logic                 wr_ready,
  output logic [2*COORD_W-1:0] ball_loc,
  output logic [2*COORD_W-1:0] barl_loc,
  output logic [2*COORD_W-1:0] barr_loc,
  output logic                 pending,
  output logic                 frame_tick,
  output logic [15:0]          frame_cnt
);

  localparam int LW = 2 * COORD_W;
  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_ACTIVE - 1);
  localparam logic [LW-1:0] BALL_RST = {COORD_W'(BALL_RST_Y), COORD_W'(BALL_RST_X)};
  localparam logic [LW-1:0] BARL_RST = {COORD_W'(BARL_RST_Y), COORD_W'(BARL_RST_X)};
  localparam logic [LW-1:0] BARR_RST = {COORD_W'(BARR_RST_Y), COORD_W'(BARR_RST_X)};

  state_t state;

  logic               rise;
  logic               wr_acc;
  logic               commit_req;
  logic               do_commit;
  logic [COORD_W-1:0] in_x, in_y, cl_x, cl_y;
  logic [LW-1:0]      cl_loc;
  logic [LW-1:0]      ball_stg, barl_stg, barr_stg;

  // Commits align to vertical blank only, so the horizontal scan position
  // carries no information this block needs.
  logic unused_pixel_x;
  assign unused_pixel_x = ^pixel_x;

  im_vblank_det #(
    .COORD_W  (COORD_W),
    .V_ACTIVE (V_ACTIVE)
  ) u_vblank_det (
    .clk     (clk),
    .rst     (rst),
    .pixel_y (pixel_y),
    .rise    (rise)
  );

  // wr_ready depends on the state register only.
  assign wr_ready   = (state != ST_COMMIT);
  assign wr_acc     = wr_valid && wr_ready;
  assign commit_req = wr_acc && (wr_sel == SEL_COMMIT);
  assign do_commit  = (state == ST_COMMIT);

  // Clamp incoming coordinates into the visible area.
  assign in_x   = wr_data[COORD_W-1:0];
  assign in_y   = wr_data[LW-1:COORD_W];
  assign cl_x   = (in_x > X_MAX) ? X_MAX : in_x;
  assign cl_y   = (in_y > Y_MAX) ? Y_MAX : in_y;
  assign cl_loc = {cl_y, cl_x};

  iob_reg #(.DATA_W(LW), .RST_VAL(BALL_RST)) u_ball_stg (
    .clk(clk), .rst(rst), .en(wr_acc && (wr_sel == SEL_BALL)),
    .data_in(cl_loc), .data_out(ball_stg));
  iob_reg #(.DATA_W(LW), .RST_VAL(BARL_RST)) u_barl_stg (
    .clk(clk), .rst(rst), .en(wr_acc && (wr_sel == SEL_BARL)),
    .data_in(cl_loc), .data_out(barl_stg));
  iob_reg #(.DATA_W(LW), .RST_VAL(BARR_RST)) u_barr_stg (
    .clk(clk), .rst(rst), .en(wr_acc && (wr_sel == SEL_BARR)),
    .data_in(cl_loc), .data_out(barr_stg));

  iob_reg #(.DATA_W(LW), .RST_VAL(BALL_RST)) u_ball_act (
    .clk(clk), .rst(rst), .en(do_commit), .data_in(ball_stg), .data_out(ball_loc));
  iob_reg #(.DATA_W(LW), .RST_VAL(BARL_RST)) u_barl_act (
    .clk(clk), .rst(rst), .en(do_commit), .data_in(barl_stg), .data_out(barl_loc));
  iob_reg #(.DATA_W(LW), .RST_VAL(BARR_RST)) u_barr_act (
    .clk(clk), .rst(rst), .en(do_commit), .data_in(barr_stg), .data_out(barr_loc));

  // Commit FSM plus registered pending flag, frame tick and frame counter.
  // A request arriving together with a rise only arms; the commit then
  // lands on the following frame's rise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      pending    <= 1'b0;
      frame_tick <= 1'b0;
      frame_cnt  <= 16'd0;
    end else begin
      frame_tick <= rise;
      if (rise) frame_cnt <= frame_cnt + 16'd1;
      case (state)
        ST_IDLE: begin
          if (commit_req) begin
            state   <= ST_ARMED;
            pending <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (rise) state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          state   <= ST_IDLE;
          pending <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          pending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iob_im_frame_ctrl.sv
// Directed bench for iob_im_frame_ctrl: reset values, basic commit timing,
// uncommitted writes, clamping, same-cycle request/rise, last-write-wins,
// reset while armed and frame counter wrap.
module tb_iob_im_frame_ctrl;

  logic        clk;
  logic        rst;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        wr_valid;
  logic [1:0]  wr_sel;
  logic [19:0] wr_data;
  logic        wr_ready;
  logic [19:0] ball_loc;
  logic [19:0] barl_loc;
  logic [19:0] barr_loc;
  logic        pending;
  logic        frame_tick;
  logic [15:0] frame_cnt;

  int tests;
  int failed;

  localparam logic [19:0] BALL_RST = {10'd240, 10'd320};
  localparam logic [19:0] BARL_RST = {10'd240, 10'd16};
  localparam logic [19:0] BARR_RST = {10'd240, 10'd623};

  iob_im_frame_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .wr_valid   (wr_valid),
    .wr_sel     (wr_sel),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .ball_loc   (ball_loc),
    .barl_loc   (barl_loc),
    .barr_loc   (barr_loc),
    .pending    (pending),
    .frame_tick (frame_tick),
    .frame_cnt  (frame_cnt)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] loc(input int y, input int x);
    return {y[9:0], x[9:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic wr(input logic [1:0] sel, input logic [19:0] data);
    wr_valid = 1'b1;
    wr_sel   = sel;
    wr_data  = data;
    tick();
    wr_valid = 1'b0;
    wr_sel   = 2'd0;
    wr_data  = 20'd0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    tests    = 0;
    failed   = 0;
    rst      = 1'b0;
    pixel_x  = 10'd0;
    pixel_y  = 10'd500;
    wr_valid = 1'b0;
    wr_sel   = 2'd0;
    wr_data  = 20'd0;

    // Reset values
    do_reset();
    chk("rst_ball", 32'(ball_loc), 32'(BALL_RST));
    chk("rst_barl", 32'(barl_loc), 32'(BARL_RST));
    chk("rst_barr", 32'(barr_loc), 32'(BARR_RST));
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_ready", 32'(wr_ready), 32'd1);
    tick();
    chk("rst_no_tick", 32'(frame_tick), 32'd0);
    chk("rst_no_cnt", 32'(frame_cnt), 32'd0);

    // Basic commit
    pixel_y = 10'd10;
    tick();
    wr(2'd0, loc(100, 200));
    wr(2'd3, 20'd0);
    chk("bc_pending_m1", 32'(pending), 32'd1);
    chk("bc_ball_held", 32'(ball_loc), 32'(BALL_RST));
    pixel_y = 10'd200;
    tick();
    chk("bc_pending_mid", 32'(pending), 32'd1);
    pixel_y = 10'd479;
    tick();
    chk("bc_pending_479", 32'(pending), 32'd1);
    chk("bc_ready_479", 32'(wr_ready), 32'd1);
    pixel_y = 10'd480;
    tick();
    chk("bc_tick_n1", 32'(frame_tick), 32'd1);
    chk("bc_cnt_n1", 32'(frame_cnt), 32'd1);
    chk("bc_ready_n1", 32'(wr_ready), 32'd0);
    chk("bc_pending_n1", 32'(pending), 32'd1);
    chk("bc_ball_n1", 32'(ball_loc), 32'(BALL_RST));
    tick();
    chk("bc_ready_n2", 32'(wr_ready), 32'd1);
    chk("bc_pending_n2", 32'(pending), 32'd0);
    chk("bc_ball_n2", 32'(ball_loc), 32'(loc(100, 200)));
    chk("bc_tick_n2", 32'(frame_tick), 32'd0);
    chk("bc_barl_n2", 32'(barl_loc), 32'(BARL_RST));

    // No commit request over three frames
    pixel_y = 10'd10;
    do_reset();
    wr(2'd1, loc(50, 16));
    for (int f = 0; f < 3; f++) begin
      pixel_y = 10'd10;
      tick();
      pixel_y = 10'd480;
      tick();
      chk("nc_tick_hi", 32'(frame_tick), 32'd1);
      tick();
      chk("nc_tick_lo", 32'(frame_tick), 32'd0);
    end
    chk("nc_cnt", 32'(frame_cnt), 32'd3);
    chk("nc_barl", 32'(barl_loc), 32'(BARL_RST));
    chk("nc_pending", 32'(pending), 32'd0);

    // Clamping
    pixel_y = 10'd10;
    tick();
    wr(2'd0, loc(600, 700));
    wr(2'd3, 20'd0);
    pixel_y = 10'd480;
    tick();
    tick();
    chk("cl_ball", 32'(ball_loc), 32'(loc(479, 639)));
    chk("cl_cnt", 32'(frame_cnt), 32'd4);

    // Request in the same cycle as the rise, then last write wins
    pixel_y = 10'd10;
    tick();
    pixel_y = 10'd480;
    wr(2'd3, 20'd0);
    chk("sc_tick", 32'(frame_tick), 32'd1);
    chk("sc_pending", 32'(pending), 32'd1);
    chk("sc_ready", 32'(wr_ready), 32'd1);
    chk("sc_cnt", 32'(frame_cnt), 32'd5);
    wr(2'd0, loc(10, 10));
    wr(2'd0, loc(20, 20));
    wr(2'd3, 20'd0);
    chk("sc_ball_held", 32'(ball_loc), 32'(loc(479, 639)));
    chk("sc_pending_held", 32'(pending), 32'd1);
    pixel_y = 10'd10;
    tick();
    pixel_y = 10'd480;
    tick();
    chk("sc_ready_commit", 32'(wr_ready), 32'd0);
    chk("sc_ball_n1", 32'(ball_loc), 32'(loc(479, 639)));
    tick();
    chk("sc_ball_n2", 32'(ball_loc), 32'(loc(20, 20)));
    chk("sc_pending_n2", 32'(pending), 32'd0);
    chk("sc_cnt_n2", 32'(frame_cnt), 32'd6);

    // Reset while armed
    pixel_y = 10'd10;
    tick();
    wr(2'd0, loc(7, 7));
    wr(2'd3, 20'd0);
    chk("ra_pending", 32'(pending), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("ra_pending_rst", 32'(pending), 32'd0);
    chk("ra_ball_rst", 32'(ball_loc), 32'(BALL_RST));
    chk("ra_cnt_rst", 32'(frame_cnt), 32'd0);
    chk("ra_ready_rst", 32'(wr_ready), 32'd1);
    tick();
    pixel_y = 10'd480;
    tick();
    chk("ra_tick", 32'(frame_tick), 32'd1);
    chk("ra_cnt", 32'(frame_cnt), 32'd1);
    chk("ra_ready", 32'(wr_ready), 32'd1);
    tick();
    chk("ra_ball_after", 32'(ball_loc), 32'(BALL_RST));
    chk("ra_pending_after", 32'(pending), 32'd0);

    // Frame counter wrap
    force dut.frame_cnt = 16'hFFFF;
    #1;
    release dut.frame_cnt;
    pixel_y = 10'd10;
    tick();
    chk("wr_cnt_hold", 32'(frame_cnt), 32'h0000FFFF);
    pixel_y = 10'd480;
    tick();
    chk("wr_cnt_wrap", 32'(frame_cnt), 32'd0);
    chk("wr_tick", 32'(frame_tick), 32'd1);
    tick();
    chk("wr_cnt_stay", 32'(frame_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
